// File: rtl/dma_bus_if.sv
// Read/write request-response bus between the DMA engine and memory.
// Every channel is a valid/ready handshake: a transfer happens on a rising
// edge where both valid and ready are high; once raised, valid and its
// payload stay stable until that edge (reset excepted).
interface dma_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_rsp_valid;
  logic                  rd_rsp_ready;
  logic [DATA_WIDTH-1:0] rd_rsp_data;
  logic                  rd_rsp_err;
  logic                  wr_req_valid;
  logic                  wr_req_ready;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic [DATA_WIDTH-1:0] wr_req_data;
  logic                  wr_rsp_valid;
  logic                  wr_rsp_ready;
  logic                  wr_rsp_err;

  modport master (
    output rd_req_valid, rd_req_addr, rd_rsp_ready,
    output wr_req_valid, wr_req_addr, wr_req_data, wr_rsp_ready,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err,
    input  wr_req_ready, wr_rsp_valid, wr_rsp_err
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_rsp_ready,
    input  wr_req_valid, wr_req_addr, wr_req_data, wr_rsp_ready,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err,
    output wr_req_ready, wr_rsp_valid, wr_rsp_err
  );
endinterface

// File: rtl/dma_transfer_ctrl.sv
// Single-beat-at-a-time copy engine: reads one word from src, writes it to
// dst, and repeats until length bytes are moved or a slave reports an error.
module dma_transfer_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic                  irq_enable,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  irq,
  output logic [2:0]            dbg_state,
  dma_bus_if.master             bus
);

  localparam int BPB = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BPB);
  localparam logic [ADDR_WIDTH-1:0] BPB_A = ADDR_WIDTH'(BPB);
  localparam logic [LEN_WIDTH-1:0]  BPB_L = LEN_WIDTH'(BPB);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  misaligned;

  // Any nonzero low bit in src, dst or length means a partial beat.
  assign misaligned = (|src_addr[OFF-1:0]) | (|dst_addr[OFF-1:0]) | (|length[OFF-1:0]);

  // Request payloads come straight from registers, so they cannot move during a stall.
  assign bus.rd_req_addr = src_q;
  assign bus.wr_req_addr = dst_q;
  assign bus.wr_req_data = data_q;
  assign dbg_state       = state;

  // Transfer FSM; all status and handshake outputs are registered here.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      irq              <= 1'b0;
      bus.rd_req_valid <= 1'b0;
      bus.rd_rsp_ready <= 1'b0;
      bus.wr_req_valid <= 1'b0;
      bus.wr_rsp_ready <= 1'b0;
      src_q            <= '0;
      dst_q            <= '0;
      rem_q            <= '0;
      data_q           <= '0;
    end else begin
      irq <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            rem_q <= length;
            done  <= 1'b0;
            error <= 1'b0;
            if (length == '0) begin
              done <= 1'b1;
              irq  <= irq_enable;
            end else if (misaligned) begin
              done  <= 1'b1;
              error <= 1'b1;
              irq   <= irq_enable;
            end else begin
              busy             <= 1'b1;
              bus.rd_req_valid <= 1'b1;
              state            <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (bus.rd_req_ready) begin
            bus.rd_req_valid <= 1'b0;
            bus.rd_rsp_ready <= 1'b1;
            state            <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.rd_rsp_valid) begin
            bus.rd_rsp_ready <= 1'b0;
            if (bus.rd_rsp_err) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              error <= 1'b1;
              irq   <= irq_enable;
              state <= IDLE;
            end else begin
              data_q           <= bus.rd_rsp_data;
              bus.wr_req_valid <= 1'b1;
              state            <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (bus.wr_req_ready) begin
            bus.wr_req_valid <= 1'b0;
            bus.wr_rsp_ready <= 1'b1;
            state            <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.wr_rsp_valid) begin
            bus.wr_rsp_ready <= 1'b0;
            if (bus.wr_rsp_err) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              error <= 1'b1;
              irq   <= irq_enable;
              state <= IDLE;
            end else begin
              // Addresses wrap naturally at 2^ADDR_WIDTH.
              src_q <= src_q + BPB_A;
              dst_q <= dst_q + BPB_A;
              rem_q <= rem_q - BPB_L;
              if (rem_q == BPB_L) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                irq   <= irq_enable;
                state <= IDLE;
              end else begin
                bus.rd_req_valid <= 1'b1;
                state            <= RD_ADDR;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_transfer_ctrl.sv
// Directed bench for dma_transfer_ctrl with a stalling memory responder.
module tb_dma_transfer_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 32;

  // ---------------- clock / reset ----------------
  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          start;
  logic          irq_enable;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic          error;
  logic          irq;
  logic [2:0]    dbg_state;

  always #5 ACLK = ~ACLK;

  dma_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dma_transfer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .start      (start),
    .irq_enable (irq_enable),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .irq        (irq),
    .dbg_state  (dbg_state),
    .bus        (bus)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];     // expected writes: {addr, data}
  logic [31:0] rd_exp_q[$];  // expected read addresses

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] mem [logic [31:0]];
  int          stall_max = 0;
  int          err_beat  = 0;   // 1-based read beat that returns an error, 0 = none
  int          rd_st, wr_st, rd_cnt, wr_cnt;
  int          rd_reqs, wr_reqs, viol;
  logic        rd_hold, wr_hold;
  logic [31:0] rd_hold_v, rd_a;
  logic [63:0] wr_hold_v;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a;
  endfunction

  function automatic int stall();
    return int'($urandom_range(stall_max, 0));
  endfunction

  task automatic slave_reset();
    bus.rd_req_ready = 1'b0;
    bus.rd_rsp_valid = 1'b0;
    bus.rd_rsp_data  = '0;
    bus.rd_rsp_err   = 1'b0;
    bus.wr_req_ready = 1'b0;
    bus.wr_rsp_valid = 1'b0;
    bus.wr_rsp_err   = 1'b0;
    rd_st = 0; wr_st = 0;
    rd_cnt = stall(); wr_cnt = stall();
    rd_hold = 1'b0; wr_hold = 1'b0;
  endtask

  // Runs on every falling edge; whatever it drives is sampled at the next rising edge.
  task automatic slave_step();
    logic [63:0] wv;
    if (ARESET) begin
      slave_reset();
      return;
    end
    case (rd_st)
      0: begin
        bus.rd_rsp_valid = 1'b0;
        bus.rd_rsp_err   = 1'b0;
        bus.rd_req_ready = 1'b0;
        if (bus.rd_req_valid) begin
          if (rd_hold && bus.rd_req_addr !== rd_hold_v) viol++;
          rd_hold = 1'b1;
          rd_hold_v = bus.rd_req_addr;
          if (rd_cnt > 0) rd_cnt--;
          else begin
            bus.rd_req_ready = 1'b1;
            rd_hold = 1'b0;
            rd_a = bus.rd_req_addr;
            rd_reqs++;
            if (rd_exp_q.size() == 0) check_eq("rd_unexpected", 1, 0);
            else check_eq("rd_addr", rd_a, rd_exp_q.pop_front());
            rd_st = 1;
            rd_cnt = stall();
          end
        end
      end
      1: begin
        bus.rd_req_ready = 1'b0;
        if (rd_cnt > 0) rd_cnt--;
        else if (bus.rd_rsp_ready) begin
          bus.rd_rsp_valid = 1'b1;
          bus.rd_rsp_data  = mem_rd(rd_a);
          bus.rd_rsp_err   = (rd_reqs == err_beat);
          rd_st = 2;
        end
      end
      default: begin
        bus.rd_rsp_valid = 1'b0;
        bus.rd_rsp_err   = 1'b0;
        rd_st = 0;
        rd_cnt = stall();
      end
    endcase
    case (wr_st)
      0: begin
        bus.wr_rsp_valid = 1'b0;
        bus.wr_req_ready = 1'b0;
        if (bus.wr_req_valid) begin
          wv = {bus.wr_req_addr, bus.wr_req_data};
          if (wr_hold && wv !== wr_hold_v) viol++;
          wr_hold = 1'b1;
          wr_hold_v = wv;
          if (wr_cnt > 0) wr_cnt--;
          else begin
            bus.wr_req_ready = 1'b1;
            wr_hold = 1'b0;
            wr_reqs++;
            if (exp_q.size() == 0) check_eq("wr_unexpected", 1, 0);
            else check_eq("wr_addr_data", wv, exp_q.pop_front());
            wr_st = 1;
            wr_cnt = stall();
          end
        end
      end
      1: begin
        bus.wr_req_ready = 1'b0;
        if (wr_cnt > 0) wr_cnt--;
        else if (bus.wr_rsp_ready) begin
          bus.wr_rsp_valid = 1'b1;
          bus.wr_rsp_err   = 1'b0;
          wr_st = 2;
        end
      end
      default: begin
        bus.wr_rsp_valid = 1'b0;
        wr_st = 0;
        wr_cnt = stall();
      end
    endcase
  endtask

  initial forever begin
    @(negedge ACLK);
    slave_step();
  end

  // ---------------- driver tasks ----------------
  int busy_n, irq_n, cyc;

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                        input logic ie);
    rd_reqs = 0; wr_reqs = 0; viol = 0;
    src_addr = s; dst_addr = d; length = l; irq_enable = ie;
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  task automatic wait_done();
    busy_n = 0; irq_n = 0; cyc = 0;
    while (cyc < 3000) begin
      busy_n += int'(busy);
      irq_n  += int'(irq);
      if (done) break;
      cyc++;
      @(negedge ACLK);
    end
    if (cyc >= 3000) check_eq("done_timeout", done, 1);
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int beats);
    for (int i = 0; i < beats; i++) begin
      rd_exp_q.push_back(s + 32'(4 * i));
      exp_q.push_back({d + 32'(4 * i), mem_rd(s + 32'(4 * i))});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ARESET = 1'b1; start = 1'b0; irq_enable = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    rd_reqs = 0; wr_reqs = 0; viol = 0;
    for (int i = 0; i < 4; i++) mem[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
    slave_reset();
    repeat (3) @(negedge ACLK);
    check_eq("reset_outs", {busy, done, error, irq, bus.rd_req_valid, bus.rd_rsp_ready,
                            bus.wr_req_valid, bus.wr_rsp_ready, dbg_state}, 0);
    ARESET = 1'b0;
    @(negedge ACLK);

    // Zero-wait 4-beat copy with interrupt.
    push_copy(32'h1000, 32'h2000, 4);
    launch(32'h1000, 32'h2000, 16, 1'b1);
    wait_done();
    check_eq("t1_done", done, 1);
    check_eq("t1_error", error, 0);
    check_eq("t1_busy_cycles", busy_n, 16);
    check_eq("t1_latency", cyc, 16);
    check_eq("t1_irq_count", irq_n, 1);
    check_eq("t1_writes", wr_reqs, 4);
    check_eq("t1_exp_left", exp_q.size(), 0);
    @(negedge ACLK);
    check_eq("t1_irq_drop", irq, 0);
    check_eq("t1_done_sticky", done, 1);

    // Same copy with random stalls on every channel.
    stall_max = 5;
    push_copy(32'h1000, 32'h2000, 4);
    launch(32'h1000, 32'h2000, 16, 1'b1);
    wait_done();
    check_eq("t2_done", done, 1);
    check_eq("t2_error", error, 0);
    check_eq("t2_reads", rd_reqs, 4);
    check_eq("t2_writes", wr_reqs, 4);
    check_eq("t2_irq_count", irq_n, 1);
    check_eq("t2_stable", viol, 0);
    check_eq("t2_exp_left", exp_q.size(), 0);
    stall_max = 0;
    repeat (8) @(negedge ACLK);

    // Zero length: done without traffic.
    launch(32'h1000, 32'h2000, 0, 1'b0);
    wait_done();
    check_eq("t3a_flags", {done, error}, 2'b10);
    check_eq("t3a_latency", cyc, 0);
    check_eq("t3a_traffic", rd_reqs + wr_reqs, 0);
    check_eq("t3a_irq", irq_n, 0);

    // Misaligned source: error without traffic.
    launch(32'h1002, 32'h2000, 8, 1'b0);
    wait_done();
    repeat (3) @(negedge ACLK);
    check_eq("t3b_flags", {done, error}, 2'b11);
    check_eq("t3b_traffic", rd_reqs + wr_reqs, 0);
    check_eq("t3b_irq", irq_n + int'(irq), 0);

    // Read error on beat 2: only the first word is written.
    err_beat = 2;
    push_copy(32'h1000, 32'h2000, 2);
    void'(exp_q.pop_back());
    launch(32'h1000, 32'h2000, 12, 1'b0);
    wait_done();
    repeat (3) @(negedge ACLK);
    check_eq("t4_flags", {done, error}, 2'b11);
    check_eq("t4_reads", rd_reqs, 2);
    check_eq("t4_writes", wr_reqs, 1);
    check_eq("t4_exp_left", exp_q.size() + rd_exp_q.size(), 0);
    err_beat = 0;

    // New start clears the sticky flags.
    push_copy(32'h1000, 32'h2000, 1);
    launch(32'h1000, 32'h2000, 4, 1'b0);
    check_eq("t4b_cleared", {busy, done, error}, 3'b100);
    wait_done();
    check_eq("t4b_flags", {done, error}, 2'b10);
    check_eq("t4b_writes", wr_reqs, 1);

    // Source address wraps through zero.
    push_copy(32'hFFFF_FFFC, 32'h3000, 2);
    launch(32'hFFFF_FFFC, 32'h3000, 8, 1'b0);
    wait_done();
    check_eq("t5_flags", {done, error}, 2'b10);
    check_eq("t5_exp_left", exp_q.size() + rd_exp_q.size(), 0);

    // Reset while a write request is pending.
    push_copy(32'h1000, 32'h2000, 1);
    launch(32'h1000, 32'h2000, 16, 1'b1);
    cyc = 0;
    while (!bus.wr_req_valid && cyc < 50) begin
      cyc++;
      @(negedge ACLK);
    end
    check_eq("t6_reached_wr_req", dbg_state, 3'd3);
    #1 ARESET = 1'b1;
    #1 check_eq("t6_async_reset", {busy, done, error, irq, bus.rd_req_valid, bus.rd_rsp_ready,
                                   bus.wr_req_valid, bus.wr_rsp_ready, dbg_state}, 0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    exp_q.delete();
    rd_exp_q.delete();
    @(negedge ACLK);
    push_copy(32'h1000, 32'h2000, 1);
    launch(32'h1000, 32'h2000, 4, 1'b0);
    wait_done();
    check_eq("t6_after_flags", {done, error}, 2'b10);
    check_eq("t6_after_writes", wr_reqs, 1);
    check_eq("t6_exp_left", exp_q.size() + rd_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
